// File: rtl/udc_pkg.sv
// Shared definitions for the up/down modulo counter: direction/mode encodings
// and the next-count rule. The prescaler is compiled in with UDC_PRESCALE_EN.
package udc_pkg;

    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Functions cannot be width-parameterised, so the rule works at the widest
    // supported counter width and callers truncate.
    localparam int unsigned UDC_MAX_W = 32;

    typedef struct packed {
        logic [UDC_MAX_W-1:0] nxt;
        logic                 tc;
    } udc_step_t;

    function automatic udc_step_t udc_next_count(
        input logic [UDC_MAX_W-1:0] count,
        input logic [UDC_MAX_W-1:0] mod_val,
        input logic                 dir,
        input logic                 sat_mode
    );
        udc_step_t res;
        res.nxt = count;
        res.tc  = 1'b0;
        if (dir == DIR_UP) begin
            if (count < mod_val) begin
                res.nxt = count + UDC_MAX_W'(1);
            end else begin
                res.nxt = (sat_mode == MODE_SAT) ? mod_val : '0;
                res.tc  = 1'b1;
            end
        end else begin
            if (count == '0) begin
                res.nxt = (sat_mode == MODE_SAT) ? '0 : mod_val;
                res.tc  = 1'b1;
            end else if (count > mod_val) begin
                // Bound lowered underneath the count: pull back in range silently.
                res.nxt = mod_val;
            end else begin
                res.nxt = count - UDC_MAX_W'(1);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/updown_counter_mod_if.sv
// Control/status bundle of the up/down modulo counter.
// presc_div only exists when UDC_PRESCALE_EN is defined.
interface updown_counter_mod_if #(
    parameter int unsigned WIDTH = 4
`ifdef UDC_PRESCALE_EN
    , parameter int unsigned PRESC_W = 8
`endif
);
    logic             en;
    logic             dir;
    logic             sat_mode;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] mod_val;
    logic [WIDTH-1:0] count;
    logic             tc;
`ifdef UDC_PRESCALE_EN
    logic [PRESC_W-1:0] presc_div;

    modport master (
        output en, dir, sat_mode, load, load_val, mod_val, presc_div,
        input  count, tc
    );
    modport slave (
        input  en, dir, sat_mode, load, load_val, mod_val, presc_div,
        output count, tc
    );
`else
    modport master (
        output en, dir, sat_mode, load, load_val, mod_val,
        input  count, tc
    );
    modport slave (
        input  en, dir, sat_mode, load, load_val, mod_val,
        output count, tc
    );
`endif
endinterface

// File: rtl/udc_prescaler.sv
// Enable divider: counts 0..div while en is high and ticks on reaching div.
// Frozen while en is low, cleared by clr.
module udc_prescaler #(
    parameter int unsigned PRESC_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               clr,
    input  logic [PRESC_W-1:0] div,
    output logic               tick
);

    logic [PRESC_W-1:0] cnt_q;
    logic               at_div;

    // >= so a runtime decrease of div below the current phase still ticks.
    assign at_div = (cnt_q >= div);
    assign tick   = en && !clr && at_div;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= at_div ? '0 : cnt_q + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/updown_counter_mod.sv
// Parametrised up/down modulo counter with load, wrap/saturate and terminal count.
// Define UDC_PRESCALE_EN to compile in the enable prescaler and presc_div.
module updown_counter_mod
    import udc_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned PRESC_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    updown_counter_mod_if.slave  bus
);

    logic [WIDTH-1:0] count_q;
    logic             tc_q;
    logic             tick;
    logic [WIDTH-1:0] load_clamp;
    logic [WIDTH-1:0] count_nxt;
    udc_step_t        step_res;
    logic             unused_step;

`ifdef UDC_PRESCALE_EN
    udc_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (bus.en),
        .clr   (bus.load),
        .div   (bus.presc_div),
        .tick  (tick)
    );
`else
    logic unused_presc_w;
    assign unused_presc_w = (PRESC_W == 0);
    assign tick           = 1'b1;
`endif

    // Next value if this cycle is a step; WIDTH must not exceed UDC_MAX_W.
    always_comb begin
        step_res  = udc_next_count(UDC_MAX_W'(count_q), UDC_MAX_W'(bus.mod_val),
                                   bus.dir, bus.sat_mode);
        count_nxt = WIDTH'(step_res.nxt);
    end

    assign unused_step = ^step_res.nxt;
    assign load_clamp  = (bus.load_val < bus.mod_val) ? bus.load_val : bus.mod_val;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else if (bus.load) begin
            count_q <= load_clamp;
            tc_q    <= 1'b0;
        end else if (bus.en && tick) begin
            count_q <= count_nxt;
            tc_q    <= step_res.tc;
        end else begin
            tc_q    <= 1'b0;
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;

endmodule

// File: doc/updown_counter_mod.md
# updown_counter_mod

Parametrised up/down modulo counter that generalises the team's fixed 4-bit free-running down counter. It adds configurable width, a runtime modulus, direction select, count enable, synchronous parallel load, wrap or saturate mode, and a terminal-count pulse. It serves as the general-purpose timebase and event counter for downstream timers and sequencers.

## Interface
- WIDTH, 4, counter width in bits (≥2)
- PRESC_W, 8, prescaler divisor width (used only with the prescaler compiled in)
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- en  input  1  count enable
- dir  input  1  1 = count up, 0 = count down
- sat_mode  input  1  1 = saturate at bounds, 0 = wrap
- load  input  1  synchronous load strobe
- load_val  input  WIDTH  value loaded on load
- mod_val  input  WIDTH  upper bound; count range is 0..mod_val inclusive
- presc_div  input  PRESC_W  prescale divisor minus one (present only with UDC_PRESCALE_EN)
- count  output  WIDTH  current count, registered
- tc  output  1  terminal-count pulse, registered

## Operation
- Reset (reset low, asynchronous): count=0, tc=0, prescaler=0.
- Priority per cycle: reset > load > step > hold.
- Load: count ← min(load_val, mod_val); tc=0; prescaler cleared. en is ignored in a load cycle.
- Step: occurs on a cycle with en=1, load=0, and a prescaler tick (without the prescaler, a tick occurs every cycle).
- Up, count < mod_val: count+1, tc=0.
- Up, count ≥ mod_val: wrap mode gives count=0; saturate mode gives count=mod_val. tc=1 in both modes.
- Down, 0 < count ≤ mod_val: count−1, tc=0.
- Down, count=0: wrap mode gives count=mod_val; saturate mode holds at 0. tc=1 in both modes.
- Down, count > mod_val (mod_val lowered at runtime): count=mod_val, tc=0.
- No step: count holds, tc=0.
- Saturated: tc pulses on every step attempted at the bound, not only on the first.
- mod_val=0: count stays 0; every step asserts tc.
- dir, sat_mode and mod_val are sampled every cycle. They may change at any time; the change takes effect on the next step.
- All arithmetic is in WIDTH bits, unsigned. There is no wrap through 2^WIDTH other than the rules above.

## Timing
- count and tc update on the rising clk edge of the step cycle and are visible in the following cycle.
- tc is a one-cycle pulse aligned with the new (wrapped or saturated) count value.
- Load latency is 1 cycle.
- Reset deassertion is synchronised externally; the first step can occur on the first edge after reset rises.
- Reset asserted mid-count forces count=0 and tc=0 immediately, without waiting for a clock edge.

## Configuration
- UDC_PRESCALE_EN defined:
  - presc_div port and PRESC_W prescaler present.
  - The prescaler counts 0..presc_div while en=1 and ticks on reaching presc_div, then returns to 0.
  - presc_div=0 gives a tick every enabled cycle.
  - en=0 freezes the prescaler. load clears it.
- UDC_PRESCALE_EN undefined:
  - No presc_div port, no prescaler logic.
  - The tick is tied to 1, so the counter steps on every enabled cycle.

## Structure
- Shared package udc_pkg holds:
  - localparams DIR_DOWN=0, DIR_UP=1
  - MODE_WRAP=0, MODE_SAT=1
  - a next-count function (count, mod_val, dir, sat_mode) → {next, tc}
- One sub-module: udc_prescaler (clk, reset, en, clr, div, tick), instantiated only under UDC_PRESCALE_EN.

## Test plan
All scenarios use WIDTH=4.
- Reset, wrap mode: reset low for 10 ns, then mod_val=15, dir=0, en=1. Expected: count=0, then 15, 14, 13…; tc high in the cycle count shows 15.
- Up-count wrap: mod_val=9, dir=1, sat_mode=0. Expected: 0..9, then 0 with tc=1 for one cycle; repeats every 10 steps.
- Saturate: mod_val=5, dir=1, sat_mode=1 from count=3. Expected: 4, 5, 5, 5; tc=1 on each step at 5. Then dir=0 gives 4 with tc=0.
- Load and clamp: load=1 with load_val=12 and mod_val=7. Expected: count=7 next cycle. A simultaneous load and en gives the load value, not a step.
- Runtime mod_val change: count=8, mod_val lowered to 4. With dir=1, the next step gives 0 with tc=1. With dir=0, the next step gives 4 with tc=0.
- Prescaler (UDC_PRESCALE_EN): presc_div=2, dir=1. Expected: count increments every 3rd enabled cycle. en low for 2 cycles stretches the interval by 2. Asserting reset mid-interval gives count=0 immediately.
